// File: rtl/contador_rolhas_vedacao.sv
// Cork count and capping sequencer for the capping station: tracks corks loaded by the
// dispenser, runs one timed actuator cycle per bottle, and reports BCD digits and a capped total.
module contador_rolhas_vedacao #(
    parameter int MAX_COUNT     = 99,
    parameter int TEMPO_VEDACAO = 4,
    parameter int LARGURA_TOTAL = 14
) (
    input  logic                     CLOCK,
    input  logic                     RESET,
    input  logic                     LOAD_CONTADOR,
    input  logic [6:0]               VALOR_CARGA,
    input  logic                     GARRAFA_PRESENTE,
    output logic [6:0]               COUNT_ATUAL,
    output logic [3:0]               BCD_DEZENA,
    output logic [3:0]               BCD_UNIDADE,
    output logic                     ATUADOR_ROLHA,
    output logic                     VEDACAO_OK,
    output logic                     FALTA_ROLHA,
    output logic [LARGURA_TOTAL-1:0] TOTAL_VEDADAS
);

    localparam int TW = (TEMPO_VEDACAO > 1) ? $clog2(TEMPO_VEDACAO) : 1;

    typedef enum logic [1:0] {
        OCIOSO,
        AGUARDA_ROLHA,
        VEDANDO,
        LIBERA
    } estado_t;

    estado_t         estado, estado_next;
    logic [TW-1:0]   timer, timer_next;
    logic            garrafa_prev;
    logic            borda;
    logic            consumo;
    logic            inc_total;
    logic [6:0]      base;
    logic [6:0]      count_next;

    function automatic logic [6:0] satura_carga(input logic [6:0] valor);
        if (valor > 7'(MAX_COUNT))
            return 7'(MAX_COUNT);
        return valor;
    endfunction

    assign borda = GARRAFA_PRESENTE & ~garrafa_prev;

    // A load and a consumption in the same cycle both take effect: the loaded value is decremented.
    assign base       = LOAD_CONTADOR ? satura_carga(VALOR_CARGA) : COUNT_ATUAL;
    assign count_next = (consumo && (base != 7'd0)) ? base - 7'd1 : base;

    always_comb begin
        estado_next = estado;
        timer_next  = timer;
        consumo     = 1'b0;
        inc_total   = 1'b0;
        case (estado)
            OCIOSO: begin
                if (borda) begin
                    if (COUNT_ATUAL != 7'd0) begin
                        estado_next = VEDANDO;
                        timer_next  = TW'(TEMPO_VEDACAO - 1);
                        consumo     = 1'b1;
                    end else begin
                        estado_next = AGUARDA_ROLHA;
                    end
                end
            end
            AGUARDA_ROLHA: begin
                // A removed bottle takes priority: there is nothing left to cap.
                if (!GARRAFA_PRESENTE) begin
                    estado_next = OCIOSO;
                end else if (base != 7'd0) begin
                    estado_next = VEDANDO;
                    timer_next  = TW'(TEMPO_VEDACAO - 1);
                    consumo     = 1'b1;
                end
            end
            VEDANDO: begin
                if (timer == '0) begin
                    estado_next = LIBERA;
                    inc_total   = 1'b1;
                end else begin
                    timer_next = timer - TW'(1);
                end
            end
            LIBERA: begin
                estado_next = OCIOSO;
            end
            default: begin
                estado_next = OCIOSO;
            end
        endcase
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            estado        <= OCIOSO;
            timer         <= '0;
            garrafa_prev  <= 1'b0;
            COUNT_ATUAL   <= 7'd0;
            TOTAL_VEDADAS <= '0;
            ATUADOR_ROLHA <= 1'b0;
            VEDACAO_OK    <= 1'b0;
            FALTA_ROLHA   <= 1'b0;
        end else begin
            estado        <= estado_next;
            timer         <= timer_next;
            garrafa_prev  <= GARRAFA_PRESENTE;
            COUNT_ATUAL   <= count_next;
            TOTAL_VEDADAS <= TOTAL_VEDADAS + LARGURA_TOTAL'(inc_total);
            ATUADOR_ROLHA <= (estado_next == VEDANDO);
            VEDACAO_OK    <= (estado_next == LIBERA);
            FALTA_ROLHA   <= (estado_next == AGUARDA_ROLHA);
        end
    end

    assign BCD_DEZENA  = 4'(COUNT_ATUAL / 7'd10);
    assign BCD_UNIDADE = 4'(COUNT_ATUAL % 7'd10);

endmodule
